pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the Enable and Flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register.
- Resolves load-use hazards, taken-branch/jump redirects, multi-cycle mul/div occupancy of EX, and data-memory wait states with timeout.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
MEM_TIMEOUT, 64, max consecutive MEM wait cycles before abort; legal range 2..255.

Ports:
CLK  input  1  clock, rising edge.
RESET  input  1  synchronous, active-high reset.
ID_Rs1  input  5  rs1 of instruction in ID.
ID_Rs2  input  5  rs2 of instruction in ID.
ID_UsesRs1  input  1  ID instruction reads rs1.
ID_UsesRs2  input  1  ID instruction reads rs2.
EX_RegDst  input  5  destination register of instruction in EX.
EX_MemRead  input  1  EX instruction is a load.
EX_Redirect  input  1  EX resolved taken branch or jump.
EX_MulDivStart  input  1  EX holds a valid mul/div op (level).
MulDivDone  input  1  mul/div unit result valid (1-cycle pulse).
MEM_Req  input  1  MEM stage has a valid load/store.
MEM_Ready  input  1  data memory completes the access this cycle.
PC_Enable  output  1  PC register load enable.
IF_ID_Enable  output  1  IF/ID register enable.
IF_ID_Flush  output  1  load NOP into IF/ID.
ID_EX_Enable  output  1  ID/EX register enable.
ID_EX_Flush  output  1  load bubble (all control fields 0) into ID/EX.
EX_MEM_Enable  output  1  EX/MEM register enable.
EX_MEM_Flush  output  1  load bubble into EX/MEM.
MEM_WB_Enable  output  1  MEM/WB register enable.
MemError  output  1  1-cycle pulse on MEM timeout abort.
StallCycles  output  32  saturating count of cycles with PC_Enable=0.

Behaviour:
- States: RUN, MD_WAIT, MEM_WAIT. Reset (RESET=1 at CLK edge) -> RUN, wait counter 0, StallCycles 0.
- While RESET=1: all Enables 0, all Flushes 0, MemError 0. Outputs are combinational from state and inputs otherwise; state, counters and MemError are registered.
- Default (no hazard): all Enables 1, all Flushes 0.
- Priority (highest first): MEM stall, redirect, mul/div, load-use.
- MEM stall:
  - MEM_Req=1 and MEM_Ready=0 in RUN or MEM_WAIT -> all Enables 0, no Flushes.
  - Next state MEM_WAIT; wait counter increments.
  - MEM_Ready=1 -> normal advance this cycle; next state RUN; counter cleared.
  - If the counter reaches MEM_TIMEOUT-1 while still not ready, that cycle:
    - EX_MEM_Flush=1 with EX_MEM_Enable=1.
    - MEM_WB_Enable=1; PC, IF_ID and ID_EX held.
    - MemError=1 on the next cycle; state returns to RUN.
- Redirect (EX_Redirect=1, no MEM stall):
  - PC_Enable=1, IF_ID_Flush=1, ID_EX_Flush=1 (2 wrong-path slots squashed).
  - EX_MEM and MEM_WB enabled. Any load-use condition is ignored.
- Mul/div:
  - EX_MulDivStart=1 in RUN with MulDivDone=0 -> enter MD_WAIT.
  - In both that cycle and all MD_WAIT cycles: PC, IF_ID and ID_EX held; EX_MEM_Enable=1 with EX_MEM_Flush=1; MEM_WB enabled.
  - MulDivDone=1 (in RUN or MD_WAIT) -> normal advance; next state RUN.
  - A MEM stall during MD_WAIT freezes everything; MD_WAIT is retained. A MulDivDone arriving during a freeze is lost, so the mul/div unit must hold Done until EX_MEM_Enable=1.
- Load-use:
  - Condition: EX_MemRead=1, EX_RegDst!=0, and (ID_UsesRs1 and ID_Rs1==EX_RegDst) or (ID_UsesRs2 and ID_Rs2==EX_RegDst).
  - Response: PC_Enable=0, IF_ID_Enable=0, ID_EX_Flush=1 with ID_EX_Enable=1. Lasts exactly one cycle; no state.
- StallCycles increments every non-reset cycle with PC_Enable=0 and saturates at 0xFFFFFFFF.
- A Flush and its matching Enable are always 1 together. A Flush never asserts while its Enable is 0.

Test Plan:
1. Reset, then no hazards for 10 cycles -> all Enables 1, Flushes 0, StallCycles 0.
2. EX_MemRead=1, EX_RegDst=5, ID_Rs2=5, ID_UsesRs2=1 -> one cycle of PC_Enable=0, IF_ID_Enable=0, ID_EX_Flush=1; StallCycles=1. Repeat with EX_RegDst=0 -> no stall.
3. Load-use and EX_Redirect together -> PC_Enable=1, IF_ID_Flush=1, ID_EX_Flush=1, no stall counted.
4. EX_MulDivStart=1, MulDivDone after 4 cycles -> 4 cycles of EX_MEM_Flush=1 with PC held, then normal advance; StallCycles=4.
5. MEM_Req=1, MEM_Ready=0 for 3 cycles, then 1 -> 3 cycles all Enables 0, advance on the 4th; MemError never set.
6. MEM_TIMEOUT=4, MEM_Req=1, MEM_Ready stuck 0 -> cycle 4 shows EX_MEM_Flush=1; MemError pulses on cycle 5. Assert RESET mid-MD_WAIT -> state RUN, StallCycles 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, redirect, mul/div occupancy and MEM wait/timeout.
// Enables/flushes are combinational from state and inputs; state, counters and MemError are registered.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  ID_Rs1,
    input  logic [4:0]  ID_Rs2,
    input  logic        ID_UsesRs1,
    input  logic        ID_UsesRs2,
    input  logic [4:0]  EX_RegDst,
    input  logic        EX_MemRead,
    input  logic        EX_Redirect,
    input  logic        EX_MulDivStart,
    input  logic        MulDivDone,
    input  logic        MEM_Req,
    input  logic        MEM_Ready,
    output logic        PC_Enable,
    output logic        IF_ID_Enable,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Enable,
    output logic        ID_EX_Flush,
    output logic        EX_MEM_Enable,
    output logic        EX_MEM_Flush,
    output logic        MEM_WB_Enable,
    output logic        MemError,
    output logic [31:0] StallCycles
);

    typedef enum logic [1:0] {RUN, MD_WAIT, MEM_WAIT} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        mem_error_q, mem_error_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic mem_stall, timeout, load_use, md_busy;

    always_comb begin
        mem_stall = MEM_Req && !MEM_Ready;
        timeout   = mem_stall && (wait_cnt_q == WAIT_LAST);
        load_use  = EX_MemRead && (EX_RegDst != 5'd0) &&
                    ((ID_UsesRs1 && (ID_Rs1 == EX_RegDst)) ||
                     (ID_UsesRs2 && (ID_Rs2 == EX_RegDst)));
        // A mul/div still in EX after a MEM wait must not slip forward, so any non-MD state may start it.
        md_busy   = !MulDivDone && ((state_q == MD_WAIT) || EX_MulDivStart);

        PC_Enable     = 1'b1;
        IF_ID_Enable  = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Enable  = 1'b1;
        ID_EX_Flush   = 1'b0;
        EX_MEM_Enable = 1'b1;
        EX_MEM_Flush  = 1'b0;
        MEM_WB_Enable = 1'b1;
        state_d       = RUN;
        wait_cnt_d    = 8'd0;
        mem_error_d   = 1'b0;

        if (timeout) begin
            PC_Enable    = 1'b0;
            IF_ID_Enable = 1'b0;
            ID_EX_Enable = 1'b0;
            EX_MEM_Flush = 1'b1;
            mem_error_d  = 1'b1;
            state_d      = (state_q == MD_WAIT) ? MD_WAIT : RUN;
        end else if (mem_stall) begin
            PC_Enable     = 1'b0;
            IF_ID_Enable  = 1'b0;
            ID_EX_Enable  = 1'b0;
            EX_MEM_Enable = 1'b0;
            MEM_WB_Enable = 1'b0;
            wait_cnt_d    = wait_cnt_q + 8'd1;
            state_d       = (state_q == MD_WAIT) ? MD_WAIT : MEM_WAIT;
        end else if (EX_Redirect) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (md_busy) begin
            PC_Enable    = 1'b0;
            IF_ID_Enable = 1'b0;
            ID_EX_Enable = 1'b0;
            EX_MEM_Flush = 1'b1;
            state_d      = MD_WAIT;
        end else if (load_use) begin
            PC_Enable    = 1'b0;
            IF_ID_Enable = 1'b0;
            ID_EX_Flush  = 1'b1;
        end

        if (RESET) begin
            PC_Enable     = 1'b0;
            IF_ID_Enable  = 1'b0;
            IF_ID_Flush   = 1'b0;
            ID_EX_Enable  = 1'b0;
            ID_EX_Flush   = 1'b0;
            EX_MEM_Enable = 1'b0;
            EX_MEM_Flush  = 1'b0;
            MEM_WB_Enable = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (!RESET && !PC_Enable && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;

        MemError    = mem_error_q;
        StallCycles = stall_cnt_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= RUN;
            wait_cnt_q  <= 8'd0;
            mem_error_q <= 1'b0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MEM_TIMEOUT=4; control outputs packed into one byte per cycle.
module tb_pipeline_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [4:0]  ID_Rs1, ID_Rs2, EX_RegDst;
    logic        ID_UsesRs1, ID_UsesRs2, EX_MemRead, EX_Redirect;
    logic        EX_MulDivStart, MulDivDone, MEM_Req, MEM_Ready;
    logic        PC_Enable, IF_ID_Enable, IF_ID_Flush, ID_EX_Enable, ID_EX_Flush;
    logic        EX_MEM_Enable, EX_MEM_Flush, MEM_WB_Enable, MemError;
    logic [31:0] StallCycles;

    int tests_run = 0;
    int tests_failed = 0;

    // {PC_En, IF_ID_En, IF_ID_Fl, ID_EX_En, ID_EX_Fl, EX_MEM_En, EX_MEM_Fl, MEM_WB_En}
    localparam logic [7:0] C_OFF   = 8'b0000_0000;
    localparam logic [7:0] C_NORM  = 8'b1101_0101;
    localparam logic [7:0] C_LU    = 8'b0001_1101;
    localparam logic [7:0] C_REDIR = 8'b1111_1101;
    localparam logic [7:0] C_MD    = 8'b0000_0111;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .ID_UsesRs1(ID_UsesRs1), .ID_UsesRs2(ID_UsesRs2),
        .EX_RegDst(EX_RegDst), .EX_MemRead(EX_MemRead), .EX_Redirect(EX_Redirect),
        .EX_MulDivStart(EX_MulDivStart), .MulDivDone(MulDivDone),
        .MEM_Req(MEM_Req), .MEM_Ready(MEM_Ready),
        .PC_Enable(PC_Enable), .IF_ID_Enable(IF_ID_Enable), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Enable(ID_EX_Enable), .ID_EX_Flush(ID_EX_Flush),
        .EX_MEM_Enable(EX_MEM_Enable), .EX_MEM_Flush(EX_MEM_Flush),
        .MEM_WB_Enable(MEM_WB_Enable), .MemError(MemError), .StallCycles(StallCycles)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sample mid-cycle, then advance to just after the next rising edge for the next stimulus.
    task automatic step(input string tag, input logic [7:0] ctrl, input logic [31:0] stalls,
                        input logic merr);
        logic [7:0] got;
        @(negedge CLK);
        got = {PC_Enable, IF_ID_Enable, IF_ID_Flush, ID_EX_Enable, ID_EX_Flush,
               EX_MEM_Enable, EX_MEM_Flush, MEM_WB_Enable};
        check({tag, ".ctrl"}, {24'd0, got}, {24'd0, ctrl});
        check({tag, ".stall"}, StallCycles, stalls);
        check({tag, ".merr"}, {31'd0, MemError}, {31'd0, merr});
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ID_Rs1 = 5'd0; ID_Rs2 = 5'd0; ID_UsesRs1 = 1'b0; ID_UsesRs2 = 1'b0;
        EX_RegDst = 5'd0; EX_MemRead = 1'b0; EX_Redirect = 1'b0;
        EX_MulDivStart = 1'b0; MulDivDone = 1'b0; MEM_Req = 1'b0; MEM_Ready = 1'b0;
    endtask

    initial begin
        idle();
        RESET = 1'b1;
        @(posedge CLK); #1;
        step("reset", C_OFF, 0, 1'b0);
        RESET = 1'b0;

        for (int i = 0; i < 10; i++) step("idle", C_NORM, 0, 1'b0);

        EX_MemRead = 1'b1; EX_RegDst = 5'd5; ID_Rs2 = 5'd5; ID_UsesRs2 = 1'b1;
        step("lu_rs2", C_LU, 0, 1'b0);
        EX_RegDst = 5'd0; ID_Rs2 = 5'd0;
        step("lu_r0", C_NORM, 1, 1'b0);
        EX_RegDst = 5'd7; ID_Rs2 = 5'd1; ID_Rs1 = 5'd7; ID_UsesRs1 = 1'b0;
        step("lu_rs1_unused", C_NORM, 1, 1'b0);
        ID_UsesRs1 = 1'b1;
        step("lu_rs1", C_LU, 1, 1'b0);
        EX_MemRead = 1'b0;
        step("lu_noload", C_NORM, 2, 1'b0);

        EX_MemRead = 1'b1; EX_Redirect = 1'b1;
        step("redir_lu", C_REDIR, 2, 1'b0);
        idle();
        step("after_redir", C_NORM, 2, 1'b0);

        EX_MulDivStart = 1'b1;
        for (int i = 0; i < 4; i++) step("md_wait", C_MD, 32'(2 + i), 1'b0);
        MulDivDone = 1'b1;
        step("md_done", C_NORM, 6, 1'b0);
        idle();
        step("after_md", C_NORM, 6, 1'b0);

        EX_Redirect = 1'b1; MEM_Req = 1'b1;
        for (int i = 0; i < 3; i++) step("mem_wait", C_OFF, 32'(6 + i), 1'b0);
        MEM_Ready = 1'b1;
        step("mem_ready", C_REDIR, 9, 1'b0);
        idle();
        step("after_mem", C_NORM, 9, 1'b0);

        MEM_Req = 1'b1;
        for (int i = 0; i < 3; i++) step("to_wait", C_OFF, 32'(9 + i), 1'b0);
        step("to_abort", C_MD, 12, 1'b0);
        MEM_Req = 1'b0;
        step("to_err", C_NORM, 13, 1'b1);
        step("to_err_clr", C_NORM, 13, 1'b0);

        EX_MulDivStart = 1'b1;
        step("md_start2", C_MD, 13, 1'b0);
        MEM_Req = 1'b1;
        step("md_memfrz", C_OFF, 14, 1'b0);
        MulDivDone = 1'b1;
        step("md_done_lost", C_OFF, 15, 1'b0);
        MEM_Req = 1'b0; MulDivDone = 1'b0; EX_MulDivStart = 1'b0;
        step("md_kept", C_MD, 16, 1'b0);

        RESET = 1'b1;
        step("rst_mid_md", C_OFF, 17, 1'b0);
        step("rst_hold", C_OFF, 0, 1'b0);
        RESET = 1'b0;
        step("rst_run", C_NORM, 0, 1'b0);
        step("rst_run2", C_NORM, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
